// File: rtl/m_expect_pkg.sv
// ============================================================================
//  m_expect_pkg
//  Shared state/error encodings and a small index helper for m_expect_arb.
//  Rev 1.0
// ============================================================================
`default_nettype none

package m_expect_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        ARB   = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_SPURIOUS = 2'd2
    } err_e;

    // Increment an index modulo n (n need not be a power of two).
    function automatic int f_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_pri_arb.sv
// ============================================================================
//  m_pri_arb
//  Combinational max-priority select with lowest-index or rotating tie-break.
//  Rev 1.0
// ============================================================================
`default_nettype none

module m_pri_arb #(
    parameter int N_CH  = 2,
    parameter int PRI_W = 2,
    parameter int RR_EN = 1
) (
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH*PRI_W-1:0]   pri_level,
    input  logic [$clog2(N_CH)-1:0] rr_ptr,
    output logic                    any_req,
    output logic [N_CH-1:0]         gnt,
    output logic [$clog2(N_CH)-1:0] gnt_idx
);
    import m_expect_pkg::*;

    localparam int IDX_W = $clog2(N_CH);

    logic [PRI_W-1:0] w_max;
    logic [N_CH-1:0]  w_cand;
    logic [IDX_W:0]   w_j;
    logic             w_found;

    always_comb begin
        w_max = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (req[i] && (pri_level[i*PRI_W +: PRI_W] > w_max)) begin
                w_max = pri_level[i*PRI_W +: PRI_W];
            end
        end
    end

    // Candidates: requesters sitting at the winning priority level.
    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_cand
            assign w_cand[g] = req[g] && (pri_level[g*PRI_W +: PRI_W] == w_max);
        end
    endgenerate

    // Scan candidates starting at the pointer (or at 0), wrapping once.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_j = (RR_EN != 0) ? ({1'b0, rr_ptr} + (IDX_W+1)'(k)) : (IDX_W+1)'(k);
            if (w_j >= (IDX_W+1)'(N_CH)) begin
                w_j = w_j - (IDX_W+1)'(N_CH);
            end
            if (!w_found && w_cand[w_j[IDX_W-1:0]]) begin
                w_found                  = 1'b1;
                gnt[w_j[IDX_W-1:0]]      = 1'b1;
                gnt_idx                  = w_j[IDX_W-1:0];
            end
        end
    end

    assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/m_expect_arb.sv
// ============================================================================
//  m_expect_arb
//  N-channel priority arbiter with bounded ack wait and data capture.
//  Rev 1.0
// ============================================================================
`default_nettype none

module m_expect_arb #(
    parameter int N_CH    = 2,
    parameter int PRI_W   = 2,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 8,
    parameter int RR_EN   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ready,
    input  logic                      go,
    input  logic [N_CH-1:0]           req,
    input  logic [N_CH*PRI_W-1:0]     pri_level,
    input  logic [N_CH-1:0]           ack,
    input  logic [N_CH*DATA_W-1:0]    data_in,
    output logic [N_CH-1:0]           gnt,
    output logic [$clog2(N_CH)-1:0]   gnt_ch,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                err_code,
    output logic [DATA_W-1:0]         data_out
);
    import m_expect_pkg::*;

    localparam int IDX_W = $clog2(N_CH);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_e             r_state, w_state;
    logic [TMR_W-1:0]   r_timer, w_timer;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr;

    logic [N_CH-1:0]    w_gnt;
    logic [IDX_W-1:0]   w_gnt_ch;
    logic               w_busy;
    logic               w_done;
    logic [1:0]         w_err;
    logic [DATA_W-1:0]  w_data;
    logic               w_end;

    logic               w_any;
    logic [N_CH-1:0]    w_arb_gnt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic [DATA_W-1:0]  w_data_sel;

    m_pri_arb #(
        .N_CH  (N_CH),
        .PRI_W (PRI_W),
        .RR_EN (RR_EN)
    ) u_pri_arb (
        .req       (req),
        .pri_level (pri_level),
        .rr_ptr    (r_rr_ptr),
        .any_req   (w_any),
        .gnt       (w_arb_gnt),
        .gnt_idx   (w_arb_idx)
    );

    always_comb begin
        w_data_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_ch == IDX_W'(i)) begin
                w_data_sel = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state  = r_state;
        w_timer  = r_timer;
        w_rr_ptr = r_rr_ptr;
        w_gnt    = gnt;
        w_gnt_ch = gnt_ch;
        w_done   = 1'b0;
        w_err    = err_code;
        w_data   = data_out;
        w_end    = 1'b0;

        case (r_state)
            IDLE: begin
                if (ready) w_state = ARMED;
            end
            ARMED: begin
                if (!ready)  w_state = IDLE;
                else if (go) w_state = ARB;
            end
            ARB: begin
                if (!ready) begin
                    w_state = IDLE;
                end else if (w_any) begin
                    w_gnt    = w_arb_gnt;
                    w_gnt_ch = w_arb_idx;
                    w_timer  = '0;
                    w_state  = WAIT;
                end
            end
            WAIT: begin
                if (r_timer != TMR_W'(TIMEOUT)) begin
                    w_timer = r_timer + TMR_W'(1);
                end
                // Granted ack beats a simultaneous stray ack.
                if (ack[gnt_ch]) begin
                    w_end  = 1'b1;
                    w_err  = ERR_OK;
                    w_data = w_data_sel;
                end else if (|(ack & ~gnt)) begin
                    w_end = 1'b1;
                    w_err = ERR_SPURIOUS;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    w_end = 1'b1;
                    w_err = ERR_TIMEOUT;
                end
                if (w_end) begin
                    w_done   = 1'b1;
                    w_gnt    = '0;
                    w_rr_ptr = IDX_W'(f_wrap_inc(int'(gnt_ch), N_CH));
                    w_state  = DONE;
                end
            end
            DONE: begin
                w_state = ready ? ARMED : IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        w_busy = (w_state == ARB) || (w_state == WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_rr_ptr <= '0;
            gnt      <= '0;
            gnt_ch   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_code <= ERR_OK;
            data_out <= '0;
        end else begin
            r_state  <= w_state;
            r_timer  <= w_timer;
            r_rr_ptr <= w_rr_ptr;
            gnt      <= w_gnt;
            gnt_ch   <= w_gnt_ch;
            busy     <= w_busy;
            done     <= w_done;
            err_code <= w_err;
            data_out <= w_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_m_expect_arb.sv
// ============================================================================
//  tb_m_expect_arb
//  Scoreboard bench: two 4-channel instances (round-robin on / off).
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_m_expect_arb;

    localparam int N_CH    = 4;
    localparam int PRI_W   = 2;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    ready;
    logic                    go;
    logic [N_CH-1:0]         req;
    logic [N_CH*PRI_W-1:0]   pri_level;
    logic [N_CH-1:0]         ack;
    logic [N_CH*DATA_W-1:0]  data_in;

    logic [N_CH-1:0]   gnt_a,      gnt_b;
    logic [1:0]        gnt_ch_a,   gnt_ch_b;
    logic              busy_a,     busy_b;
    logic              done_a,     done_b;
    logic [1:0]        err_a,      err_b;
    logic [DATA_W-1:0] dout_a,     dout_b;

    m_expect_arb #(.N_CH(N_CH), .PRI_W(PRI_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .RR_EN(1)) u_dut_rr (
        .clk(clk), .rst(rst), .ready(ready), .go(go), .req(req), .pri_level(pri_level),
        .ack(ack), .data_in(data_in), .gnt(gnt_a), .gnt_ch(gnt_ch_a), .busy(busy_a),
        .done(done_a), .err_code(err_a), .data_out(dout_a)
    );

    m_expect_arb #(.N_CH(N_CH), .PRI_W(PRI_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .RR_EN(0)) u_dut_fix (
        .clk(clk), .rst(rst), .ready(ready), .go(go), .req(req), .pri_level(pri_level),
        .ack(ack), .data_in(data_in), .gnt(gnt_b), .gnt_ch(gnt_ch_b), .busy(busy_b),
        .done(done_b), .err_code(err_b), .data_out(dout_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [1:0]  err;
        int          lat;
        logic [31:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_data = '0;
    bit          chk_b    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ch_data(input int ch);
        logic [N_CH*DATA_W-1:0] v;
        v = data_in;
        return v[ch*DATA_W +: DATA_W];
    endfunction

    // Monitor for the round-robin instance
    logic [N_CH-1:0] prev_gnt_a = '0;
    int              lat_a = 0;
    always @(negedge clk) begin
        lat_a++;
        if (gnt_a != '0 && prev_gnt_a == '0) begin
            if (q_a.size() == 0) begin
                chk("unexp_gnt", 32'(gnt_a), 32'h0);
            end else begin
                chk("gnt_ch", 32'(gnt_ch_a), 32'(q_a[0].ch));
                chk("gnt_onehot", 32'(gnt_a), 32'(1) << q_a[0].ch);
                chk("busy_wait", 32'(busy_a), 32'h1);
            end
            lat_a = 0;
        end
        if (done_a) begin
            if (q_a.size() == 0) begin
                chk("unexp_done", 32'(done_a), 32'h0);
            end else begin
                chk("done_lat", 32'(lat_a), 32'(q_a[0].lat));
                chk("err_code", 32'(err_a), 32'(q_a[0].err));
                chk("data_out", dout_a, q_a[0].data);
                chk("gnt_clr", 32'(gnt_a), 32'h0);
                void'(q_a.pop_front());
            end
        end
        prev_gnt_a = gnt_a;
    end

    // Monitor for the fixed-priority instance, only during the tie-break test
    logic [N_CH-1:0] prev_gnt_b = '0;
    always @(negedge clk) begin
        if (chk_b) begin
            if (gnt_b != '0 && prev_gnt_b == '0) begin
                if (q_b.size() == 0) chk("fix_unexp_gnt", 32'(gnt_b), 32'h0);
                else                 chk("fix_gnt_ch", 32'(gnt_ch_b), 32'(q_b[0].ch));
            end
            if (done_b) begin
                if (q_b.size() == 0) begin
                    chk("fix_unexp_done", 32'(done_b), 32'h0);
                end else begin
                    chk("fix_err", 32'(err_b), 32'(q_b[0].err));
                    void'(q_b.pop_front());
                end
            end
        end
        prev_gnt_b = gnt_b;
    end

    task automatic start_txn(input logic [3:0] r, input logic [7:0] p, input int ch,
                             input logic [1:0] err, input int lat, input logic [31:0] d);
        exp_t e;
        e.ch = ch; e.err = err; e.lat = lat; e.data = d;
        q_a.push_back(e);
        ready     = 1'b1;
        go        = 1'b1;
        req       = r;
        pri_level = p;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (gnt_a != '0) break;
        end
        chk("gnt_seen", 32'(gnt_a != '0), 32'h1);
        // Dropping req in WAIT must not disturb the transaction
        go  = 1'b0;
        req = '0;
    endtask

    task automatic do_ack(input int k, input logic [3:0] a);
        repeat (k - 1) @(negedge clk);
        ack = a;
        @(negedge clk);
        ack = '0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && (q_a.size() != 0 || q_b.size() != 0); i++) begin
            @(negedge clk);
        end
        chk("sb_drain", 32'(q_a.size() + q_b.size()), 32'h0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},    32'(gnt_a),    32'h0);
        chk({tag, "_gnt_ch"}, 32'(gnt_ch_a), 32'h0);
        chk({tag, "_busy"},   32'(busy_a),   32'h0);
        chk({tag, "_done"},   32'(done_a),   32'h0);
        chk({tag, "_err"},    32'(err_a),    32'h0);
        chk({tag, "_data"},   dout_a,        32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        ready     = 1'b0;
        go        = 1'b0;
        req       = '0;
        pri_level = '0;
        ack       = '0;
        data_in   = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Basic: ch1 has higher priority, acked in the 2nd WAIT cycle
        exp_data = ch_data(1);
        start_txn(4'b0011, 8'h09, 1, 2'd0, 2, exp_data);
        do_ack(2, 4'b0010);
        wait_done(40);

        // Timeout: ch0 never acked, data_out holds its value
        start_txn(4'b0001, 8'h00, 0, 2'd1, TIMEOUT, exp_data);
        wait_done(40);

        // Spurious: stray ack only, then stray plus granted ack together
        start_txn(4'b0001, 8'h00, 0, 2'd2, 1, exp_data);
        do_ack(1, 4'b0010);
        wait_done(40);
        exp_data = ch_data(0);
        start_txn(4'b0001, 8'h00, 0, 2'd0, 1, exp_data);
        do_ack(1, 4'b0011);
        wait_done(40);

        // Equal-priority tie-break, four back-to-back transactions from reset
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        exp_data = '0;
        chk_b    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.ch = i; e.err = 2'd1; e.lat = TIMEOUT; e.data = 32'h0;
            q_a.push_back(e);
            e.ch = 0;
            q_b.push_back(e);
        end
        ready     = 1'b1;
        go        = 1'b1;
        req       = 4'hF;
        pri_level = 8'hFF;
        wait_done(200);
        go    = 1'b0;
        req   = '0;
        chk_b = 1'b0;
        repeat (3) @(negedge clk);

        // Abort: ready drops while waiting in ARB with no requests
        go = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_busy_arb", 32'(busy_a), 32'h1);
        ready = 1'b0;
        go    = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_idle", 32'(busy_a), 32'h0);
        chk("abort_gnt", 32'(gnt_a), 32'h0);

        // Reset in the middle of WAIT
        start_txn(4'b0100, 8'h00, 2, 2'd1, TIMEOUT, exp_data);
        repeat (2) @(negedge clk);
        void'(q_a.pop_front());
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_idle_busy", 32'(busy_a), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/m_expect_arb.md
# m_expect_arb

Parametrised successor to the two-channel `ready`/`go`/`req`/`ack` handshake block. Arbitrates among `N_CH` requesters by programmable priority and grants one channel per transaction. Waits for that channel's acknowledge with a bounded timeout, then captures the acknowledged data word. Sits between the requesting agents and the shared target; it is also the DUT for the `expect`-based handshake assertions in the chapter 4 benches.

## Interface
Parameters:
- `N_CH`, 2: number of req/ack channels, 2..16.
- `PRI_W`, 2: width of each channel's priority level.
- `DATA_W`, 32: width of each channel's data word.
- `TIMEOUT`, 8: maximum cycles to wait for ack, at least 1.
- `RR_EN`, 1: 1 = round-robin among equal-priority requesters; 0 = lowest index wins.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `ready`, in, 1: target ready; enables arming.
- `go`, in, 1: transaction start, sampled in ARMED.
- `req`, in, N_CH: per-channel request.
- `pri_level`, in, N_CH*PRI_W: channel i priority in bits [i*PRI_W +: PRI_W]; larger value = higher priority.
- `ack`, in, N_CH: per-channel acknowledge from target.
- `data_in`, in, N_CH*DATA_W: channel i data in bits [i*DATA_W +: DATA_W].
- `gnt`, out, N_CH: one-hot grant.
- `gnt_ch`, out, $clog2(N_CH): index of the granted channel.
- `busy`, out, 1: high in ARB and WAIT.
- `done`, out, 1: one-cycle pulse at transaction end.
- `err_code`, out, 2: 0 = OK, 1 = TIMEOUT, 2 = SPURIOUS; valid while `done` is high, held until the next `done`.
- `data_out`, out, DATA_W: data captured at ack.

## Operation
- All outputs are registered.
- Reset values: `gnt`=0, `gnt_ch`=0, `busy`=0, `done`=0, `err_code`=0, `data_out`=0, state=IDLE, round-robin pointer=0, timer=0.
- **IDLE**: if `ready`=1, go to ARMED.
- **ARMED**:
  - `ready`=0: go to IDLE; this takes precedence over `go`.
  - `go`=1: go to ARB.
- **ARB**:
  - `ready`=0: go to IDLE with no `done` pulse.
  - Else if any `req` is high: select the highest `pri_level` among the requesting channels.
  - Ties resolve to the lowest index when `RR_EN`=0. When `RR_EN`=1, ties resolve to the first tied index at or after the RR pointer, wrapping.
  - On selection: set `gnt`/`gnt_ch`, clear the timer, go to WAIT.
  - No `req`: remain in ARB indefinitely.
- **WAIT**: timer increments each cycle. Conditions checked in this order:
  1. `ack[gnt_ch]`=1: capture `data_in[gnt_ch]` into `data_out`, `err_code`=OK.
  2. Else any other `ack` bit high: `err_code`=SPURIOUS.
  3. Else timer = TIMEOUT-1: `err_code`=TIMEOUT.
  - In all three cases: pulse `done`, clear `gnt`, advance the RR pointer to `gnt_ch`+1 modulo N_CH, go to DONE.
  - If the granted ack and a spurious ack arrive in the same cycle, the result is OK; the spurious ack is ignored.
- **DONE**: one cycle. Go to ARMED if `ready`=1, else IDLE.
- Priority and requests are sampled only in ARB; `req` deasserting during WAIT has no effect.
- `rst` asserted in any state returns all outputs to reset values on the next edge, including mid-WAIT; no `done` pulse is produced.
- Timer width is $clog2(TIMEOUT+1) and it never wraps.

## Timing
- `go` sampled at edge n in ARMED: ARB from n+1.
- `req` present at edge n+1: `gnt` high from n+2.
- Ack in the k-th WAIT cycle (1 ≤ k ≤ TIMEOUT), sampled at edge n+1+k: `done`, `data_out`, `err_code` valid from n+2+k; `gnt` low the same cycle.
- Timeout, with `req` at n+1: `done` from n+2+TIMEOUT.
- Minimum back-to-back spacing: DONE → ARMED → ARB → WAIT, i.e. next `gnt` 3 cycles after `done`, with `go` held high.
- `ack` earlier than the first WAIT cycle is not seen.

## Structure
- `m_expect_pkg`: `state_e` {IDLE, ARMED, ARB, WAIT, DONE} and `err_e` {ERR_OK, ERR_TIMEOUT, ERR_SPURIOUS}.
- Sub-module `m_pri_arb`: combinational max-priority/tie-break select. Inputs: `req`, `pri_level`, RR pointer. Outputs: one-hot grant and index. Parametrised on N_CH, PRI_W, RR_EN.
- Top level holds the FSM, timer, RR pointer and data capture.

## Test plan
- **Basic** (N_CH=2): `ready`, then `go`, `req`=2'b11, `pri_level`={2,1}, `ack[1]` 2 cycles after grant → `gnt`=2'b10, `gnt_ch`=1, `done` with ERR_OK, `data_out`=`data_in[1]`.
- **Timeout** (TIMEOUT=8): grant ch0, never ack → `done` exactly 8 WAIT cycles after `gnt`, `err_code`=1, `data_out` unchanged.
- **Round-robin** (RR_EN=1, 4 channels all priority 3, `req`=4'hF, 4 back-to-back transactions) → grants 0,1,2,3; with RR_EN=0 → grants 0,0,0,0.
- **Spurious**: ch0 granted, `ack`=2'b10 → ERR_SPURIOUS; repeat with `ack`=2'b11 → ERR_OK.
- **Abort/reset**: `ready` dropped in ARB → IDLE, no `done`; `rst` mid-WAIT → all outputs 0 next cycle, no `done`.
